// File: rtl/pattern_tx_pkg.sv
// Shared state encoding and default sizing for the serial pattern transmitter.
package pattern_tx_pkg;

  localparam int WIDTH_DEF    = 6;
  localparam int REPEAT_W_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pattern_tx_shreg.sv
// Parallel-load, shift-left register exposing its MSB; load wins over shift.
// Latency: 1 cycle from load to MSB; no backpressure, the enables are obeyed every cycle.
module pattern_shreg
  import pattern_tx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeat_cnt+1 times back-to-back.
// Latency: first bit 2 cycles after the accept edge, busy for N+3 cycles; no backpressure, start ignored while busy.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int REPEAT_W = REPEAT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    pattern,
  input  logic [REPEAT_W-1:0] repeat_cnt,
  output logic                dout,
  output logic                valid,
  output logic                busy,
  output logic                done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t              state;
  logic [WIDTH-1:0]    hold;
  logic [REPEAT_W-1:0] rep;
  logic [CW-1:0]       bitcnt;

  logic             sh_load;
  logic             sh_shift;
  logic [WIDTH-1:0] sh_din;
  logic             sh_msb;

  // The shift register is loaded from the live pattern on accept and from
  // the hold copy on each repeat, so later pattern changes never leak in.
  always_comb begin
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_din   = hold;
    case (state)
      S_IDLE: begin
        sh_load = start;
        sh_din  = pattern;
      end
      S_SHIFT: begin
        sh_shift = 1'b1;
        sh_load  = (bitcnt == '0) && (rep != '0);
      end
      default: ;
    endcase
  end

  pattern_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (sh_din),
    .msb   (sh_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      hold   <= '0;
      rep    <= '0;
      bitcnt <= '0;
      dout   <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      dout  <= 1'b0;
      valid <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            hold  <= pattern;
            rep   <= repeat_cnt;
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          bitcnt <= LAST_BIT;
          state  <= S_SHIFT;
        end
        S_SHIFT: begin
          dout  <= sh_msb;
          valid <= 1'b1;
          if (bitcnt == '0) begin
            if (rep != '0) begin
              rep    <= rep - REPEAT_W'(1);
              bitcnt <= LAST_BIT;
            end else begin
              state <= S_DONE;
            end
          end else begin
            bitcnt <= bitcnt - CW'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_tx.sv
// Directed plus randomized bench for pattern_tx against a timeline model of each frame.
module tb_pattern_tx;

  localparam int W  = 6;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  pattern;
  logic [RW-1:0] repeat_cnt;
  logic          dout, valid, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  pattern_tx #(.WIDTH(W), .REPEAT_W(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .dout       (dout),
    .valid      (valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".dout"},  dout,  1'b0);
    chk({tag, ".valid"}, valid, 1'b0);
    chk({tag, ".busy"},  busy,  1'b0);
    chk({tag, ".done"},  done,  1'b0);
  endtask

  // Model: c counts clock edges after the accept edge. Bits occupy c=2..N+1,
  // done is at c=N+2, busy spans c=0..N+2. At c==poke_c the inputs are
  // disturbed for one edge; that must not alter the frame in flight.
  task automatic send(input logic [W-1:0] pat, input logic [RW-1:0] rc,
                      input int poke_c, input logic poke_start,
                      input logic [W-1:0] poke_pat, input string tag);
    int  n;
    logic in_bits;
    n = (int'(rc) + 1) * W;
    pattern    = pat;
    repeat_cnt = rc;
    start      = 1'b1;
    for (int c = 0; c <= n + 5; c++) begin
      @(negedge clk);
      start   = 1'b0;
      in_bits = (c >= 2) && (c < n + 2);
      chk($sformatf("%s.valid[%0d]", tag, c), valid, in_bits);
      chk($sformatf("%s.dout[%0d]", tag, c), dout,
          in_bits ? pat[W - 1 - ((c - 2) % W)] : 1'b0);
      chk($sformatf("%s.busy[%0d]", tag, c), busy, c <= n + 2);
      chk($sformatf("%s.done[%0d]", tag, c), done, c == n + 2);
      if (c == poke_c) begin
        start      = poke_start;
        pattern    = poke_pat;
        repeat_cnt = ~rc;
      end
    end
  endtask

  initial begin
    logic [W-1:0]  rpat, ppat;
    logic [RW-1:0] rrc;
    int            pc, dones;

    rst = 1'b1;
    start = 1'b0;
    pattern = '0;
    repeat_cnt = '0;

    // Reset state
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    send(6'b101100, 4'd0, -1, 1'b0, 6'b101100, "single");
    send(6'b110001, 4'd2, -1, 1'b0, 6'b110001, "repeat3");
    send(6'b101100, 4'd0, 4, 1'b1, 6'b111111, "ignore_busy");
    send(6'b011010, 4'd0, 1, 1'b0, 6'b000000, "capture");
    send(6'b100111, 4'd15, 40, 1'b1, 6'b000000, "max_repeat");

    // Asynchronous reset after the third bit
    pattern = 6'b101100; repeat_cnt = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst.bit3_valid", valid, 1'b1);
    chk("midrst.bit3_dout",  dout,  1'b1);
    rst = 1'b1;
    #1;
    chk_idle("midrst.async");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_idle("midrst.stay_idle");
    end
    send(6'b101100, 4'd0, -1, 1'b0, 6'b101100, "after_rst");

    // start held high: period N+3 = 9 cycles, 3 non-valid cycles between frames
    pattern = 6'b100000; repeat_cnt = 4'd0; start = 1'b1;
    dones = 0;
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      chk($sformatf("b2b.valid[%0d]", c), valid, (c % 9) >= 2 && (c % 9) <= 7);
      chk($sformatf("b2b.dout[%0d]", c), dout, (c % 9) == 2);
      chk($sformatf("b2b.busy[%0d]", c), busy, 1'b1);
      chk($sformatf("b2b.done[%0d]", c), done, (c % 9) == 8);
      if (done) dones++;
    end
    start = 1'b0;
    n_cmp++;
    assert (dones == 3) else begin
      n_err++;
      $error("FAIL b2b.done_count observed=%0d expected=3", dones);
    end
    @(negedge clk);
    chk_idle("b2b.end");

    // Randomized frames with a random disturbance while busy
    for (int i = 0; i < 10; i++) begin
      rpat = W'($urandom);
      rrc  = RW'($urandom_range(0, 3));
      ppat = W'($urandom);
      pc   = $urandom_range(1, (int'(rrc) + 1) * W + 1);
      send(rpat, rrc, pc, 1'($urandom), ppat, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
